// File: rtl/score_keeper_pkg.sv
// rtl/score_keeper_pkg.sv - game-state, outcome encodings and BCD helper shared by the scoring slice
package score_keeper_pkg;

  localparam int STATE_BITS = 2;
  localparam logic [STATE_BITS:0] STATE_GAME = (STATE_BITS + 1)'(2);

  typedef enum logic [1:0] {
    OUT_NONE = 2'd0,
    OUT_HIT  = 2'd1,
    OUT_MISS = 2'd2
  } outcome_e;

  // Two-digit BCD of a small non-negative integer (0..99).
  function automatic logic [7:0] to_bcd2(input int value);
    return {4'((value / 10) % 10), 4'(value % 10)};
  endfunction

endpackage

// File: rtl/bcd_add4.sv
// rtl/bcd_add4.sv - combinational 4-digit BCD adder; addend digits land on the tens and hundreds positions
module bcd_add4 (
  input  logic [15:0] a,
  input  logic [7:0]  b,
  output logic [15:0] sum,
  output logic        cout
);

  logic [15:0] b_ext;
  logic [4:0]  digit;
  logic        carry;

  assign b_ext = {4'd0, b, 4'd0};

  always_comb begin
    sum   = '0;
    digit = '0;
    carry = 1'b0;
    for (int i = 0; i < 4; i++) begin
      digit = {1'b0, a[i*4 +: 4]} + {1'b0, b_ext[i*4 +: 4]} + {4'd0, carry};
      if (digit > 5'd9) begin
        digit = digit + 5'd6;
        carry = 1'b1;
      end else begin
        carry = 1'b0;
      end
      sum[i*4 +: 4] = digit[3:0];
    end
    cout = carry;
  end

endmodule

// File: rtl/score_keeper.sv
// rtl/score_keeper.sv - per-beat scoring: BCD score, combo, multiplier, lives and game-over
module score_keeper
  import score_keeper_pkg::*;
#(
  parameter int START_LIVES      = 5,
  parameter int COMBO_STEP       = 8,
  parameter int MAX_MULT         = 4,
  parameter int BASE_POINTS_TENS = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  metronome_clk,
  input  logic [STATE_BITS:0]   state,
  input  logic                  correctHit,
  input  logic                  incorrectHit,
  input  logic                  partialArrow,
  output logic [15:0]           score_bcd,
  output logic [7:0]            combo,
  output logic [7:0]            max_combo,
  output logic [3:0]            multiplier,
  output logic [2:0]            lives,
  output logic                  game_over,
  output logic                  hit_pulse,
  output logic                  miss_pulse
);

  logic [2:0]  metro_sync;
  logic        beat;
  logic        in_game;
  logic        prev_in_game;
  logic        game_entry;
  outcome_e    outcome_q;
  logic        partial_q;
  logic [7:0]  addend_bcd;
  logic [15:0] score_sum;
  logic        score_cout;
  logic [7:0]  combo_inc;
  logic [2:0]  lives_dec;

  assign beat       = metro_sync[1] & ~metro_sync[2];
  assign in_game    = (state == STATE_GAME);
  assign game_entry = in_game & ~prev_in_game;
  assign combo_inc  = (combo == 8'hFF) ? combo : combo + 8'd1;
  assign lives_dec  = (lives == 3'd0) ? 3'd0 : lives - 3'd1;

  // Multiplier follows the registered combo, so a hit is scored at the pre-hit multiplier.
  always_comb begin
    int m;
    m = 1 + int'(combo) / COMBO_STEP;
    if (m > MAX_MULT) m = MAX_MULT;
    multiplier = 4'(m);
    addend_bcd = to_bcd2(BASE_POINTS_TENS * m);
  end

  bcd_add4 u_bcd_add4 (
    .a    (score_bcd),
    .b    (addend_bcd),
    .sum  (score_sum),
    .cout (score_cout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      metro_sync   <= '0;
      prev_in_game <= 1'b0;
      outcome_q    <= OUT_NONE;
      partial_q    <= 1'b0;
    end else begin
      metro_sync   <= {metro_sync[1:0], metronome_clk};
      prev_in_game <= in_game;
      outcome_q    <= OUT_NONE;
      partial_q    <= 1'b0;
      if (!game_entry && beat && in_game && !game_over) begin
        if (incorrectHit) outcome_q <= OUT_MISS;
        else if (correctHit) outcome_q <= OUT_HIT;
        partial_q <= partialArrow;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      score_bcd  <= '0;
      combo      <= '0;
      max_combo  <= '0;
      lives      <= 3'(START_LIVES);
      game_over  <= 1'b0;
      hit_pulse  <= 1'b0;
      miss_pulse <= 1'b0;
    end else if (game_entry) begin
      score_bcd  <= '0;
      combo      <= '0;
      max_combo  <= '0;
      lives      <= 3'(START_LIVES);
      game_over  <= 1'b0;
      hit_pulse  <= 1'b0;
      miss_pulse <= 1'b0;
    end else begin
      hit_pulse  <= 1'b0;
      miss_pulse <= 1'b0;
      case (outcome_q)
        OUT_HIT: begin
          score_bcd <= score_cout ? 16'h9999 : score_sum;
          combo     <= combo_inc;
          if (combo_inc > max_combo) max_combo <= combo_inc;
          hit_pulse <= 1'b1;
        end
        OUT_MISS: begin
          lives      <= lives_dec;
          game_over  <= (lives_dec == 3'd0);
          combo      <= partial_q ? (combo >> 1) : 8'd0;
          miss_pulse <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
